// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480 @ 60 Hz raster timing generator.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_if.sv
// Raster timing bundle from the timing generator to renderers and encoder.
interface vga_if;
    import vga_pkg::*;

    logic   hs;
    logic   vs;
    logic   blank;
    coord_t DrawX;
    coord_t DrawY;
    logic   frame_start;
    logic   line_start;

    modport master (
        output hs, vs, blank, DrawX, DrawY,
        output frame_start, line_start
    );

    modport slave (
        input hs, vs, blank, DrawX, DrawY,
        input frame_start, line_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis, with look-ahead value.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output coord_t count,
    output coord_t next_count,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    assign wrap = en && (count == LAST);

    always_comb begin
        next_count = count;
        if (wrap)
            next_count = '0;
        else if (en)
            next_count = count + coord_t'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= next_count;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: position counters plus registered sync/blank/markers
// decoded from the look-ahead count so they line up with DrawX/DrawY.
module vga_timing_gen
    import vga_pkg::coord_t;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic  vga_clk,
    input  logic  reset,
    vga_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024) begin : g_h_range
        $error("H_TOTAL exceeds 10-bit coordinate range");
    end
    if (V_TOTAL > 1024) begin : g_v_range
        $error("V_TOTAL exceeds 10-bit coordinate range");
    end

    coord_t hc, hc_next;
    coord_t vc, vc_next;
    logic   h_wrap, v_wrap;

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk        (vga_clk),
        .reset      (reset),
        .en         (1'b1),
        .count      (hc),
        .next_count (hc_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk        (vga_clk),
        .reset      (reset),
        .en         (h_wrap),
        .count      (vc),
        .next_count (vc_next),
        .wrap       (v_wrap)
    );

    assign vga.DrawX = hc;
    assign vga.DrawY = vc;

    // A wrap is the only way a counter returns to 0, so the wrap flags
    // mark the next position being x==0 / (0,0).
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vga.hs          <= 1'b1;
            vga.vs          <= 1'b1;
            vga.blank       <= 1'b0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.hs          <= !(hc_next >= HS_START && hc_next < HS_END);
            vga.vs          <= !(vc_next >= VS_START && vc_next < VS_END);
            vga.blank       <= (hc_next < H_VIS) && (vc_next < V_VIS);
            vga.line_start  <= h_wrap;
            vga.frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, reduced
// instance (32x20 raster) for frame, wrap and reset corners.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   hs;
        logic   vs;
        logic   bl;
        logic   ls;
        logic   fs;
    } vout_t;

    typedef struct {
        int    n;
        vout_t e;
    } vec_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #20 vga_clk = ~vga_clk;

    vga_if vf ();
    vga_if vsm ();

    vga_timing_gen u_full (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (vf.master)
    );

    vga_timing_gen #(
        .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
        .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (4)
    ) u_small (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (vsm.master)
    );

    function automatic vout_t mk(int x, int y, bit hs, bit vs,
                                 bit bl, bit ls, bit fs);
        vout_t r;
        r.x  = coord_t'(x);
        r.y  = coord_t'(y);
        r.hs = hs;
        r.vs = vs;
        r.bl = bl;
        r.ls = ls;
        r.fs = fs;
        return r;
    endfunction

    function automatic vout_t get_f();
        return mk(int'(vf.DrawX), int'(vf.DrawY), vf.hs, vf.vs,
                  vf.blank, vf.line_start, vf.frame_start);
    endfunction

    function automatic vout_t get_s();
        return mk(int'(vsm.DrawX), int'(vsm.DrawY), vsm.hs, vsm.vs,
                  vsm.blank, vsm.line_start, vsm.frame_start);
    endfunction

    // Reduced raster: 32 px/line (hsync 20..27), 20 lines (vsync 14..15).
    function automatic vout_t sm_model(int n);
        int x, y;
        x = n % 32;
        y = (n / 32) % 20;
        return mk(x, y, !(x >= 20 && x < 28), !(y >= 14 && y < 16),
                  (x < 16 && y < 12), x == 0, (x == 0 && y == 0));
    endfunction

    task automatic chk(string nm, vout_t a, vout_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                     nm, a.x, a.y, a.hs, a.vs, a.bl, a.ls, a.fs,
                     e.x, e.y, e.hs, e.vs, e.bl, e.ls, e.fs);
        end
    endtask

    task automatic chk_i(string nm, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    vec_t tbl[12];
    vout_t rst_v;

    initial begin
        int ti;
        int hs_low, hs_first, hs_last, bl_cnt, bl_max;
        int ls_cnt, ffs_cnt, sfs_cnt, sfs_first, sfs_last, sfs_gap_bad;
        int k;
        vout_t f, s;

        tbl[0]  = '{1,    mk(1,   0, 1, 1, 1, 0, 0)};
        tbl[1]  = '{639,  mk(639, 0, 1, 1, 1, 0, 0)};
        tbl[2]  = '{640,  mk(640, 0, 1, 1, 0, 0, 0)};
        tbl[3]  = '{655,  mk(655, 0, 1, 1, 0, 0, 0)};
        tbl[4]  = '{656,  mk(656, 0, 0, 1, 0, 0, 0)};
        tbl[5]  = '{751,  mk(751, 0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{752,  mk(752, 0, 1, 1, 0, 0, 0)};
        tbl[7]  = '{799,  mk(799, 0, 1, 1, 0, 0, 0)};
        tbl[8]  = '{800,  mk(0,   1, 1, 1, 1, 1, 0)};
        tbl[9]  = '{1456, mk(656, 1, 0, 1, 0, 0, 0)};
        tbl[10] = '{1600, mk(0,   2, 1, 1, 1, 1, 0)};
        tbl[11] = '{2399, mk(799, 2, 1, 1, 0, 0, 0)};
        rst_v = mk(0, 0, 1, 1, 0, 0, 0);

        repeat (5) @(posedge vga_clk);
        @(negedge vga_clk);
        chk("reset_full", get_f(), rst_v);
        chk("reset_small", get_s(), rst_v);
        reset = 1'b0;

        ti = 0;
        hs_low = 0; hs_first = -1; hs_last = -1;
        bl_cnt = 0; bl_max = -1;
        ls_cnt = 0; ffs_cnt = 0;
        sfs_cnt = 0; sfs_first = -1; sfs_last = -1; sfs_gap_bad = 0;
        for (int n = 1; n <= 2399; n++) begin
            tick();
            f = get_f();
            s = get_s();
            if (ti < 12 && tbl[ti].n == n) begin
                chk($sformatf("full_vec_%0d", n), f, tbl[ti].e);
                ti++;
            end
            if (n >= 800 && n < 1600) begin
                if (!f.hs) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(f.x);
                    hs_last = int'(f.x);
                end
                if (f.bl) begin
                    bl_cnt++;
                    bl_max = int'(f.x);
                end
            end
            if (f.ls) ls_cnt++;
            if (f.fs) ffs_cnt++;
            chk($sformatf("small_n%0d", n), s, sm_model(n));
            if (s.fs) begin
                if (sfs_first < 0) sfs_first = n;
                else if (n - sfs_last != 640) sfs_gap_bad++;
                sfs_last = n;
                sfs_cnt++;
            end
            if (n == 384)
                chk("small_vis_end", s, mk(0, 12, 1, 1, 0, 1, 0));
            if (n == 640)
                chk("small_wrap", s, mk(0, 0, 1, 1, 1, 1, 1));
        end
        chk_i("full_table_used", ti, 12);
        chk_i("hs_low_cycles", hs_low, 96);
        chk_i("hs_first_x", hs_first, 656);
        chk_i("hs_last_x", hs_last, 751);
        chk_i("blank_cycles", bl_cnt, 640);
        chk_i("blank_last_x", bl_max, 639);
        chk_i("line_start_cnt", ls_cnt, 2);
        chk_i("full_no_fs", ffs_cnt, 0);
        chk_i("small_first_fs", sfs_first, 640);
        chk_i("small_fs_cnt", sfs_cnt, 3);
        chk_i("small_fs_gap", sfs_gap_bad, 0);

        // Mid-frame reset while both sync pulses are active.
        k = 0;
        while (!(vsm.DrawX == 10'd24 && vsm.DrawY == 10'd15) && k < 1000) begin
            tick();
            k++;
        end
        chk_i("find_24_15", int'(k < 1000), 1);
        chk("pre_midreset", get_s(), mk(24, 15, 0, 0, 0, 0, 0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_small", get_s(), rst_v);
        chk("midreset_full", get_f(), rst_v);
        tick();
        chk("post_midreset", get_s(), mk(1, 0, 1, 1, 1, 0, 0));

        // Reset held well past where line and frame wraps would fall.
        reset = 1'b1;
        for (int i = 0; i < 700; i++) begin
            tick();
            chk($sformatf("hold_small_%0d", i), get_s(), rst_v);
            chk($sformatf("hold_full_%0d", i), get_f(), rst_v);
        end
        reset = 1'b0;
        tick();
        chk("release_small", get_s(), mk(1, 0, 1, 1, 1, 0, 0));
        chk("release_full", get_f(), mk(1, 0, 1, 1, 1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
